// File: rtl/alu_divider.sv
// alu_divider: multi-cycle RV32M divide/remainder unit (div, divu, rem, remu).
// Restoring division, one quotient bit per cycle, with a start/busy/done handshake.
//
// Ports:
//   clk, rst_n      rising-edge clock, asynchronous active-low reset
//   start           request, sampled only while busy=0
//   flush           synchronous abort of any in-flight operation (wins over start)
//   control[1:0]    00 div, 01 divu, 10 rem, 11 remu
//   a, b            dividend (rs1), divisor (rs2)
//   busy            operation in progress
//   done            one-cycle pulse, result valid
//   result          quotient or remainder, held until the next completion
//
// Optional feature: define ALU_DIV_EARLY_OUT_EN to finish divide-by-zero and
// signed-overflow cases one edge after accept instead of after the full
// iteration. Result values are the same in both builds.
module alu_divider #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             flush,
    input  logic [1:0]       control,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result
);

    localparam int unsigned CW = $clog2(WIDTH + 1);
    localparam logic [WIDTH-1:0] MIN_VAL = WIDTH'(1) << (WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2
    } state_t;

    state_t           state;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] quo;
    logic [WIDTH-1:0] rem;
    logic [WIDTH-1:0] divisor;
    logic             sel_rem;
    logic             sign_q;
    logic             sign_r;
    logic             spec;
    logic [WIDTH-1:0] spec_val;

    logic             is_signed;
    logic             a_neg;
    logic             b_neg;
    logic [WIDTH-1:0] a_mag;
    logic [WIDTH-1:0] b_mag;
    logic             div_zero;
    logic             ovf;
    logic [WIDTH-1:0] special_val;
    logic [WIDTH:0]   shifted;
    logic             step_ge;
    logic [WIDTH-1:0] diff;
    logic [WIDTH-1:0] q_fix;
    logic [WIDTH-1:0] r_fix;
    logic [WIDTH-1:0] fix_val;

    // Operand conditioning and special-case detection at accept time.
    always_comb begin
        is_signed   = ~control[0];
        a_neg       = is_signed & a[WIDTH-1];
        b_neg       = is_signed & b[WIDTH-1];
        a_mag       = a_neg ? (WIDTH'(0) - a) : a;
        b_mag       = b_neg ? (WIDTH'(0) - b) : b;
        div_zero    = (b == '0);
        ovf         = is_signed && (a == MIN_VAL) && (b == '1);
        special_val = div_zero ? (control[1] ? a : '1)
                               : (control[1] ? '0 : a);
    end

    // One restoring step. The partial remainder can reach WIDTH bits with an
    // unsigned divisor, so the shifted value and comparison keep a guard bit;
    // when the subtraction succeeds the difference always fits in WIDTH bits.
    always_comb begin
        shifted = {rem, quo[WIDTH-1]};
        step_ge = (shifted >= {1'b0, divisor});
        diff    = shifted[WIDTH-1:0] - divisor;
    end

    // Sign correction and result selection for the FIX state.
    always_comb begin
        q_fix   = sign_q ? (WIDTH'(0) - quo) : quo;
        r_fix   = sign_r ? (WIDTH'(0) - rem) : rem;
        fix_val = spec ? spec_val : (sel_rem ? r_fix : q_fix);
    end

    // Control FSM and datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            cnt      <= '0;
            quo      <= '0;
            rem      <= '0;
            divisor  <= '0;
            sel_rem  <= 1'b0;
            sign_q   <= 1'b0;
            sign_r   <= 1'b0;
            spec     <= 1'b0;
            spec_val <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            result   <= '0;
        end else begin
            done <= 1'b0;
            if (flush) begin
                state <= IDLE;
                busy  <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        if (start) begin
                            sel_rem  <= control[1];
                            sign_q   <= a_neg ^ b_neg;
                            sign_r   <= a_neg;
                            quo      <= a_mag;
                            rem      <= '0;
                            divisor  <= b_mag;
                            cnt      <= CW'(WIDTH);
                            spec     <= div_zero | ovf;
                            spec_val <= special_val;
                            busy     <= 1'b1;
`ifdef ALU_DIV_EARLY_OUT_EN
                            state    <= (div_zero | ovf) ? FIX : CALC;
`else
                            state    <= CALC;
`endif
                        end
                    end
                    CALC: begin
                        quo <= {quo[WIDTH-2:0], step_ge};
                        rem <= step_ge ? diff : shifted[WIDTH-1:0];
                        cnt <= cnt - CW'(1);
                        if (cnt == CW'(1)) begin
                            state <= FIX;
                        end
                    end
                    FIX: begin
                        result <= fix_val;
                        done   <= 1'b1;
                        busy   <= 1'b0;
                        state  <= IDLE;
                    end
                    default: begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule
